// File: rtl/rv_int_ctrl.sv
// rv_int_ctrl: machine-mode trap/CSR controller with prioritised synchronised IRQs and 64-bit counters
module rv_int_ctrl #(
   parameter int          NUM_IRQ     = 4,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] MTVEC_RST   = 32'h0000_0100
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic               i_en,
   input  logic [31:0]        i_pc_current,
   input  logic [31:0]        i_pc_seq,
   input  logic [31:0]        i_inst,
   input  logic               i_ecall,
   input  logic               i_mret,
   input  logic               i_illegal_inst,
   input  logic [11:0]        i_csr_addr,
   input  logic [2:0]         i_csr_op,
   input  logic [31:0]        i_csr_src,
   input  logic               i_csr_src_zero,
   output logic [31:0]        o_csr_rdata,
   output logic               o_csr_illegal,
   output logic [31:0]        o_pc_next,
   output logic               o_trap_taken
);
   localparam logic [31:0] IE_MASK = ((32'd1 << NUM_IRQ) - 32'd1) << 16;

   logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
   logic               r_st_mie, r_st_mpie;
   logic [31:0]        r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
   logic [63:0]        r_mcycle, r_minstret;
   logic [NUM_IRQ-1:0] w_sirq, w_irq_act;
   logic [4:0]         w_irq_idx;
   logic [31:0]        w_rdata, w_wval, w_cause, w_base, w_tvec;
   logic               w_hit, w_valid, w_exc, w_trap, w_retire, w_mret, w_wr;
   logic               w_unused;

   assign w_unused = i_csr_op[2];
   assign w_sirq   = r_sync[SYNC_STAGES-1];

   // irq synchroniser chain, one stage per edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};

   // CSR read mux; unmatched addresses read zero and flag a miss
   always_comb begin
      w_rdata = 32'd0;
      w_hit   = 1'b1;
      case (i_csr_addr)
         12'h300: w_rdata = {24'd0, r_st_mpie, 3'd0, r_st_mie, 3'd0};
         12'h304: w_rdata = r_mie;
         12'h305: w_rdata = r_mtvec;
         12'h340: w_rdata = r_mscratch;
         12'h341: w_rdata = r_mepc;
         12'h342: w_rdata = r_mcause;
         12'h343: w_rdata = r_mtval;
         12'h344: w_rdata = 32'(w_sirq) << 16;
         12'hB00: w_rdata = r_mcycle[31:0];
         12'hB80: w_rdata = r_mcycle[63:32];
         12'hB02: w_rdata = r_minstret[31:0];
         12'hB82: w_rdata = r_minstret[63:32];
         default: w_hit = 1'b0;
      endcase
   end

   // lowest-numbered enabled pending line wins
   always_comb begin
      w_irq_act = w_sirq & r_mie[16 +: NUM_IRQ] & {NUM_IRQ{r_st_mie}};
      w_irq_idx = 5'd0;
      for (int k = NUM_IRQ - 1; k >= 0; k--)
         if (w_irq_act[k]) w_irq_idx = 5'(k);
   end

   assign w_valid       = i_csr_op[1:0] != 2'b00;
   assign o_csr_rdata   = w_rdata;
   assign o_csr_illegal = w_valid & ~w_hit;
   assign w_wval        = (i_csr_op[1:0] == 2'b01) ? i_csr_src :
                          (i_csr_op[1:0] == 2'b10) ? (w_rdata | i_csr_src) : (w_rdata & ~i_csr_src);
   assign w_exc         = i_illegal_inst | i_ecall;
   assign w_trap        = rst_n & i_en & (w_exc | (|w_irq_act));
   assign w_retire      = rst_n & i_en & ~w_trap;
   assign w_mret        = w_retire & i_mret;
   assign w_wr          = w_retire & w_valid & w_hit & ((i_csr_op[1:0] == 2'b01) | ~i_csr_src_zero);
   assign w_cause       = i_illegal_inst ? 32'd2 : i_ecall ? 32'd11 : (32'h8000_0000 | 32'(5'd16 + w_irq_idx));
   assign w_base        = {r_mtvec[31:2], 2'b00};
   assign w_tvec        = (!w_exc && r_mtvec[0]) ? w_base + {25'd0, 5'd16 + w_irq_idx, 2'b00} : w_base;
   assign o_trap_taken  = w_trap;
   assign o_pc_next     = w_trap ? w_tvec : w_mret ? r_mepc : i_pc_seq;

   // architectural state: trap entry, then mret, then CSR write
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_st_mie   <= 1'b0;
         r_st_mpie  <= 1'b0;
         r_mie      <= 32'd0;
         r_mtvec    <= MTVEC_RST;
         r_mscratch <= 32'd0;
         r_mepc     <= 32'd0;
         r_mcause   <= 32'd0;
         r_mtval    <= 32'd0;
      end else if (w_trap) begin
         r_mepc    <= i_pc_current;
         r_mcause  <= w_cause;
         r_mtval   <= i_illegal_inst ? i_inst : 32'd0;
         r_st_mpie <= r_st_mie;
         r_st_mie  <= 1'b0;
      end else if (w_mret) begin
         r_st_mie  <= r_st_mpie;
         r_st_mpie <= 1'b1;
      end else if (w_wr) begin
         case (i_csr_addr)
            12'h300: {r_st_mpie, r_st_mie} <= {w_wval[7], w_wval[3]};
            12'h304: r_mie      <= w_wval & IE_MASK;
            12'h305: r_mtvec    <= w_wval & ~32'd2;
            12'h340: r_mscratch <= w_wval;
            12'h341: r_mepc     <= w_wval & ~32'd3;
            12'h342: r_mcause   <= w_wval;
            12'h343: r_mtval    <= w_wval;
            default: ;
         endcase
      end

   // counters; a write to either half replaces that cycle's increment
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_mcycle   <= 64'd0;
         r_minstret <= 64'd0;
      end else begin
         r_mcycle   <= (w_wr && i_csr_addr == 12'hB00) ? {r_mcycle[63:32], w_wval} :
                       (w_wr && i_csr_addr == 12'hB80) ? {w_wval, r_mcycle[31:0]} : r_mcycle + 64'd1;
         r_minstret <= (w_wr && i_csr_addr == 12'hB02) ? {r_minstret[63:32], w_wval} :
                       (w_wr && i_csr_addr == 12'hB82) ? {w_wval, r_minstret[31:0]} :
                       w_retire ? r_minstret + 64'd1 : r_minstret;
      end
endmodule

// File: tb/tb_rv_int_ctrl.sv
// tb_rv_int_ctrl: table-driven directed checks of the trap/CSR controller
module tb_rv_int_ctrl;
   logic        clk = 0, rst_n = 0;
   logic [3:0]  irq = 0;
   logic        en = 0, ecall = 0, mret = 0, ill = 0, sz = 0;
   logic [31:0] pc_cur = 0, pc_seq = 0, inst = 0, src = 0;
   logic [11:0] addr = 0;
   logic [2:0]  op = 0;
   logic [31:0] o_rdata, o_pc_next;
   logic        o_ill, o_trap;
   int          total = 0, bad = 0;

   localparam logic [2:0] W = 3'b001, S = 3'b010, C = 3'b011, SI = 3'b110, N = 3'b000;

   rv_int_ctrl #(.NUM_IRQ(4), .SYNC_STAGES(2), .MTVEC_RST(32'h100)) dut (
      .clk(clk), .rst_n(rst_n), .i_irq(irq), .i_en(en), .i_pc_current(pc_cur), .i_pc_seq(pc_seq),
      .i_inst(inst), .i_ecall(ecall), .i_mret(mret), .i_illegal_inst(ill), .i_csr_addr(addr),
      .i_csr_op(op), .i_csr_src(src), .i_csr_src_zero(sz), .o_csr_rdata(o_rdata),
      .o_csr_illegal(o_ill), .o_pc_next(o_pc_next), .o_trap_taken(o_trap));

   always #5 clk = ~clk;

   typedef struct {
      logic en; logic [31:0] pc, seq, inst; logic ecall, mret, ill;
      logic [11:0] addr; logic [2:0] op; logic [31:0] src; logic sz;
      logic c_rd; logic [31:0] e_rd; logic e_ill; logic [31:0] e_pc; logic e_trap;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic en_, input logic [31:0] pc_, seq_, inst_, input logic ec_, mr_, il_,
                               input logic [11:0] a_, input logic [2:0] op_, input logic [31:0] s_, input logic z_,
                               input logic [31:0] erd, input logic eill, input logic [31:0] epc, input logic etr);
      vec_t v;
      v.en = en_; v.pc = pc_; v.seq = seq_; v.inst = inst_; v.ecall = ec_; v.mret = mr_; v.ill = il_;
      v.addr = a_; v.op = op_; v.src = s_; v.sz = z_; v.c_rd = 1'b1;
      v.e_rd = erd; v.e_ill = eill; v.e_pc = epc; v.e_trap = etr;
      return v;
   endfunction

   function automatic vec_t rd(input logic [31:0] pc_, input logic [11:0] a_, input logic [31:0] erd);
      return mk(1, pc_, pc_ + 4, 0, 0, 0, 0, a_, S, 0, 1, erd, 0, pc_ + 4, 0);
   endfunction

   function automatic vec_t wr(input logic [31:0] pc_, input logic [11:0] a_, input logic [2:0] op_,
                               input logic [31:0] s_, input logic [31:0] erd);
      return mk(1, pc_, pc_ + 4, 0, 0, 0, 0, a_, op_, s_, 0, erd, 0, pc_ + 4, 0);
   endfunction

   function automatic vec_t wrn(input logic [31:0] pc_, input logic [11:0] a_, input logic [31:0] s_);
      vec_t v = wr(pc_, a_, W, s_, 0);
      v.c_rd = 1'b0;
      return v;
   endfunction

   function automatic vec_t stall(input logic [31:0] pc_, input logic [11:0] a_, input logic [31:0] erd);
      return mk(0, pc_, pc_ + 4, 0, 0, 0, 0, a_, N, 0, 0, erd, 0, pc_ + 4, 0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run(input vec_t v, input int n);
      en = v.en; pc_cur = v.pc; pc_seq = v.seq; inst = v.inst; ecall = v.ecall; mret = v.mret; ill = v.ill;
      addr = v.addr; op = v.op; src = v.src; sz = v.sz;
      @(negedge clk);
      if (v.c_rd) chk($sformatf("v%0d rdata", n), o_rdata, v.e_rd);
      chk($sformatf("v%0d csr_illegal", n), {31'd0, o_ill}, {31'd0, v.e_ill});
      chk($sformatf("v%0d pc_next", n), o_pc_next, v.e_pc);
      chk($sformatf("v%0d trap", n), {31'd0, o_trap}, {31'd0, v.e_trap});
      @(posedge clk);
      #1;
   endtask

   initial begin
      en = 1; ecall = 1; pc_seq = 32'h1234; addr = 12'h305;
      #12;
      chk("rst mtvec", o_rdata, 32'h100);
      chk("rst trap", {31'd0, o_trap}, 32'd0);
      chk("rst pc_next", o_pc_next, 32'h1234);
      addr = 12'hB00; #1;
      chk("rst mcycle", o_rdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1; ecall = 0;

      tv.push_back(rd(32'h0, 12'h305, 32'h100));
      tv.push_back(wr(32'h4, 12'h340, W, 32'hDEADBEEF, 32'h0));
      tv.push_back(mk(1, 32'h8, 32'hC, 0, 0, 0, 0, 12'h340, S, 32'hFFFF, 1, 32'hDEADBEEF, 0, 32'hC, 0));
      tv.push_back(rd(32'hC, 12'h340, 32'hDEADBEEF));
      tv.push_back(wr(32'h10, 12'h343, W, 32'hF0F0F0F0, 32'h0));
      tv.push_back(wr(32'h14, 12'h343, C, 32'h00F000F0, 32'hF0F0F0F0));
      tv.push_back(rd(32'h18, 12'h343, 32'hF000F000));
      tv.push_back(mk(1, 32'h1C, 32'h20, 0, 0, 0, 0, 12'h7C0, W, 32'h5, 0, 32'h0, 1, 32'h20, 0));
      tv.push_back(wr(32'h20, 12'h300, SI, 32'h8, 32'h0));
      tv.push_back(mk(1, 32'h40, 32'h44, 0, 1, 0, 0, 12'h300, N, 0, 0, 32'h8, 0, 32'h100, 1));
      tv.push_back(rd(32'h100, 12'h341, 32'h40));
      tv.push_back(rd(32'h104, 12'h342, 32'd11));
      tv.push_back(rd(32'h108, 12'h343, 32'h0));
      tv.push_back(rd(32'h10C, 12'h300, 32'h80));
      tv.push_back(mk(1, 32'h110, 32'h114, 0, 0, 1, 0, 12'h300, N, 0, 0, 32'h80, 0, 32'h40, 0));
      tv.push_back(rd(32'h40, 12'h300, 32'h88));
      tv.push_back(mk(0, 32'h44, 32'h48, 0, 1, 0, 0, 12'h300, W, 0, 0, 32'h88, 0, 32'h48, 0));
      tv.push_back(rd(32'h44, 12'h300, 32'h88));
      tv.push_back(wr(32'h48, 12'h341, W, 32'h12345677, 32'h40));
      tv.push_back(rd(32'h4C, 12'h341, 32'h12345674));
      tv.push_back(wr(32'h50, 12'h305, W, 32'h203, 32'h100));
      tv.push_back(rd(32'h54, 12'h305, 32'h201));
      tv.push_back(wr(32'h58, 12'h304, W, 32'hFFFFFFFF, 32'h0));
      tv.push_back(rd(32'h5C, 12'h304, 32'h000F0000));
      tv.push_back(mk(1, 32'h60, 32'h64, 32'hFFFFFFFF, 0, 0, 1, 12'h343, N, 0, 0, 32'h0, 0, 32'h200, 1));
      tv.push_back(rd(32'h200, 12'h343, 32'hFFFFFFFF));
      tv.push_back(rd(32'h204, 12'h342, 32'd2));
      tv.push_back(rd(32'h208, 12'h300, 32'h80));
      tv.push_back(wr(32'h20C, 12'h300, W, 32'hFFFFFFFF, 32'h80));
      tv.push_back(rd(32'h210, 12'h300, 32'h88));
      tv.push_back(rd(32'h214, 12'h344, 32'h0));
      foreach (tv[i]) run(tv[i], i);

      run(wr(32'h2E0, 12'h304, W, 32'h30000, 32'h000F0000), 100);
      irq = 4'b0011;
      run(rd(32'h2F0, 12'h344, 32'h0), 101);
      run(rd(32'h2F4, 12'h344, 32'h0), 102);
      run(mk(1, 32'h300, 32'h304, 0, 0, 0, 0, 12'h340, W, 32'h1111, 0, 32'hDEADBEEF, 0, 32'h240, 1), 103);
      run(rd(32'h240, 12'h344, 32'h30000), 104);
      run(rd(32'h244, 12'h340, 32'hDEADBEEF), 105);
      run(rd(32'h248, 12'h342, 32'h80000010), 106);
      run(rd(32'h24C, 12'h341, 32'h300), 107);
      irq = 4'b0010;
      run(rd(32'h250, 12'h344, 32'h30000), 108);
      run(rd(32'h254, 12'h344, 32'h30000), 109);
      run(mk(1, 32'h258, 32'h25C, 0, 0, 1, 0, 12'h344, N, 0, 0, 32'h20000, 0, 32'h300, 0), 110);
      run(mk(1, 32'h300, 32'h304, 0, 0, 0, 0, 12'h342, S, 0, 1, 32'h80000010, 0, 32'h244, 1), 111);
      run(rd(32'h244, 12'h342, 32'h80000011), 112);
      run(rd(32'h248, 12'h341, 32'h300), 113);

      run(wr(32'h24C, 12'h300, SI, 32'h8, 32'h80), 120);
      run(mk(1, 32'h250, 32'h254, 32'hFFFFFFFF, 0, 0, 1, 12'h343, N, 0, 0, 32'h0, 0, 32'h200, 1), 121);
      run(rd(32'h200, 12'h343, 32'hFFFFFFFF), 122);
      run(rd(32'h204, 12'h342, 32'd2), 123);
      irq = 4'b0000;

      run(wrn(32'h208, 12'hB00, 32'h100), 130);
      run(wrn(32'h20C, 12'hB02, 32'h50), 131);
      run(stall(32'h210, 12'hB00, 32'h101), 132);
      run(stall(32'h210, 12'hB02, 32'h50), 133);
      run(stall(32'h210, 12'hB00, 32'h103), 134);
      run(stall(32'h210, 12'hB00, 32'h104), 135);
      run(stall(32'h210, 12'hB02, 32'h50), 136);
      run(wr(32'h210, 12'hB00, W, 32'hFFFFFFFF, 32'h106), 137);
      run(wr(32'h214, 12'hB80, W, 32'hFFFFFFFF, 32'h0), 138);
      run(stall(32'h218, 12'hB80, 32'hFFFFFFFF), 139);
      run(stall(32'h218, 12'hB00, 32'h0), 140);
      run(stall(32'h218, 12'hB80, 32'h0), 141);
      run(stall(32'h218, 12'hB02, 32'h52), 142);

      en = 1; ecall = 1; op = N; pc_seq = 32'h5550; addr = 12'h305;
      #2 rst_n = 0;
      #1;
      chk("midrst mtvec", o_rdata, 32'h100);
      chk("midrst trap", {31'd0, o_trap}, 32'd0);
      chk("midrst pc_next", o_pc_next, 32'h5550);
      addr = 12'h342; #1;
      chk("midrst mcause", o_rdata, 32'h0);
      addr = 12'hB00; #1;
      chk("midrst mcycle", o_rdata, 32'h0);
      addr = 12'h340; #1;
      chk("midrst mscratch", o_rdata, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rv_int_ctrl.md
Name: rv_int_ctrl

Overview:
- Parametrised machine-mode trap/CSR controller; successor of the single-source interrupt unit in the single-cycle RV32 datapath.
- Adds NUM_IRQ prioritised level-sensitive interrupt lines with input synchronisers, direct/vectored mtvec, full Zicsr read-modify-write, mtval/mscratch, and 64-bit mcycle/minstret counters.
- Sits beside Regs/ALU: selects next PC and supplies CSR read data for the MemtoReg CSR path.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..16); line i maps to cause 16+i, mie/mip bit 16+i.
- SYNC_STAGES, 2, flip-flop stages on each irq line (>=2).
- MTVEC_RST, 32'h0000_0100, mtvec reset value.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- irq  in  NUM_IRQ  asynchronous level interrupt requests
- en  in  1  instruction retires this cycle; 0 = stall, no state change except mcycle and irq synchronisers
- pc_current  in  32  PC of current instruction
- pc_seq  in  32  non-trap next PC (branch/jump/+4) from datapath
- inst  in  32  current instruction (mtval on illegal)
- ecall, mret, illegal_inst  in  1 each  decoder flags
- csr_addr  in  12  inst[31:20]
- csr_op  in  3  inst[14:12]; 001/101 write, 010/110 set, 011/111 clear, others no CSR access
- csr_src  in  32  rs1 data or zero-extended zimm (pre-selected)
- csr_src_zero  in  1  rs1 index / zimm field is zero
- csr_rdata  out  32  old value of addressed CSR (combinational)
- csr_illegal  out  1  csr_op valid and address unimplemented
- pc_next  out  32  next PC
- trap_taken  out  1  trap entry this cycle

Behaviour:
- Reset (rst_n=0, async): mstatus=0 (MIE bit3, MPIE bit7 only writable bits), mie=0, mtvec=MTVEC_RST, mscratch/mepc/mcause/mtval=0, mcycle=minstret=0, synchronisers=0. Outputs during reset: trap_taken=0, pc_next=pc_seq.
- CSR map: 300 mstatus, 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause, 343 mtval, 344 mip (read-only, bits 16+i = synchronised irq), B00/B80 mcycle lo/hi, B02/B82 minstret lo/hi. Other addresses: rdata=0, csr_illegal=1, write dropped.
- Write value: write=csr_src; set=old|csr_src; clear=old&~csr_src. Set/clear with csr_src_zero=1 perform no write. Write applied at clock edge only when en=1 and no trap. mepc[1:0] and mtvec[1] forced 0; mie bits outside [16+NUM_IRQ-1:16] read 0.
- Trap priority (en=1): illegal_inst (cause 2, mtval=inst) > ecall (cause 11, mtval=0) > interrupt: lowest index i with sync_irq[i]&mie[16+i]&MIE (cause 0x8000_0000|(16+i), mtval=0).
- Trap entry, same cycle: trap_taken=1; pc_next={mtvec[31:2],2'b00} for exceptions or when mtvec[0]=0; {mtvec[31:2],2'b00}+4*(16+i) for vectored interrupts. At edge: mepc=pc_current, mcause, mtval, MPIE<=MIE, MIE<=0; minstret not incremented.
- mret (en=1, no trap): pc_next=mepc; at edge MIE<=MPIE, MPIE<=1.
- Interrupt coinciding with mret or CSR instruction: interrupt wins; mret/CSR write suppressed, mepc=pc_current (instruction re-executes).
- en=0: trap_taken=0, pc_next=pc_seq, no architectural update.
- Counters: mcycle +1 every cycle; minstret +1 when en=1 and no trap. 64-bit wrap to 0. A CSR write to either half takes precedence over that cycle's increment of that counter.
- Interrupt latency: irq assertion visible to trap logic SYNC_STAGES edges later.

Test Plan:
- Reset with rst_n=0 mid-run -> mtvec=0x100, mcause=0, mcycle=0 immediately, no clock required.
- ecall at pc 0x40, mtvec=0x100 -> pc_next=0x100, mepc=0x40, mcause=11, MIE cleared; then mret -> pc_next=0x40, MIE restored.
- mtvec=0x201, MIE=1, mie=0x30000, irq=4'b0011 -> after 2 edges cause 0x80000010, pc_next=0x240; line 1 taken only after line 0 drops and mret.
- Illegal inst 0xFFFFFFFF with irq pending -> cause 2, mtval=0xFFFFFFFF, pc_next=0x200.
- csrrs mscratch with rs1=x0 -> no write; csrrc 0x343 clears bits; access to 0x7C0 -> csr_illegal=1, rdata=0.
- Write mcycle lo=0xFFFFFFFF, hi=0xFFFFFFFF -> next cycle reads 0/0; en=0 for 3 cycles -> minstret unchanged, mcycle +3.
